key_event_gen: RTL and testbench
================================

// Module: key_event_gen
// PURPOSE
//  Front-end key conditioner for the password-box front panel. It synchronises
//  and debounces the raw active-low push keys, then turns each key into clean
//  one-cycle events: press, release and long-press, plus a held level. It sits
//  directly upstream of the password-box control logic, which consumes
//  pressO[0] (input/advance) and pressO[3] (lock/commit).
// PARAMETERS
//  N_KEYS    4           number of independent key channels
//  DEB_CYC   240_000     consecutive stable cycles to accept a level (20 ms @ 12 MHz)
//  LONG_CYC  12_000_000  held cycles after press before longO fires (1 s)
//  REP_CYC   2_400_000   auto-repeat period in cycles (KEY_REPEAT_EN only)
// PORTS
//  clkI      in   1       system clock, 12 MHz
//  rstNI     in   1       asynchronous active-low reset
//  keyI      in   N_KEYS  raw keys, asynchronous, 0 = pressed
//  heldO     out  N_KEYS  debounced level, 1 = pressed
//  pressO    out  N_KEYS  1-cycle pulse on accepted press (and on repeats)
//  releaseO  out  N_KEYS  1-cycle pulse on accepted release
//  longO     out  N_KEYS  1-cycle pulse when held LONG_CYC cycles
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops = 1 (released); FSMs IDLE; counters 0.
//  - Sync: 2-FF synchroniser per key, so keyI reaches the debouncer 2 cycles late.
//  - Debounce: the counter increments while the synced level != debounced level.
//    The counter clears on any sample equal to the debounced level.
//    When the count reaches DEB_CYC, the debounced level flips and the counter clears.
//  - Latency: a clean keyI edge is reflected in heldO exactly DEB_CYC+2 cycles later.
//  - Glitches shorter than DEB_CYC cycles produce no event and no heldO change.
//  - Per-key FSM, states IDLE, PRESSED, LONG:
//      IDLE    -> PRESSED on debounced press; pressO=1 for that cycle; hold counter cleared.
//      PRESSED -> LONG when the hold counter reaches LONG_CYC-1; longO=1 for that cycle.
//      PRESSED -> IDLE on debounced release; releaseO=1; no longO.
//      LONG    -> IDLE on debounced release; releaseO=1.
//  - The pressO, releaseO and longO pulses are registered, and each is asserted
//    in the same cycle that heldO changes or that the state changes.
//  - The hold counter saturates in LONG and never wraps.
//  - Counter widths are $clog2(max+1).
//  - Channels are fully independent. Simultaneous events on different keys are
//    all reported in the same cycle.
//  - Reset mid-press: outputs clear at once.
//  - A key still held after reset release is treated as a new press: pressO
//    fires DEB_CYC+2 cycles after rstNI rises.
// CONFIGURATION
//  - Macro KEY_REPEAT_EN:
//      Defined: while in LONG, pressO re-pulses every REP_CYC cycles. The first
//        repeat comes REP_CYC cycles after longO. The repeat counter clears on release.
//      Undefined: no repeat logic is built, and pressO pulses once per physical press.
//  - Port list is identical in both builds.
// STRUCTURE
//  - Package key_event_pkg: key_state_t enum (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2),
//    KEY_RELEASED=1'b1 constant, and a cnt_w() width helper.
//  - Sub-module key_event_ch: one channel (sync, debounce, FSM, hold/repeat counters).
//  - key_event_gen instantiates N_KEYS copies of key_event_ch with a generate loop.
// TESTING (bench params DEB_CYC=4, LONG_CYC=20, REP_CYC=5, N_KEYS=4)
//  1. Clean tap: keyI[0]=0 for 10 cycles, then 1.
//     -> pressO[0] pulses 6 cycles after the fall; releaseO[0] 6 cycles after the rise.
//     -> longO stays 0.
//  2. Bounce: keyI[1] toggles every 2 cycles for 12 cycles, then stays 0.
//     -> exactly one pressO[1], 6 cycles after the final fall; no releaseO during the bounce.
//  3. Long hold: keyI[2]=0 for 40 cycles.
//     -> pressO[2] at cycle 6, longO[2] at cycle 26, a single releaseO[2] after the rise.
//     -> with KEY_REPEAT_EN: extra pressO[2] pulses at cycles 31, 36, 41, 46.
//  4. Simultaneous: keyI[0] and keyI[3] fall in the same cycle.
//     -> pressO=4'b1001 in a single cycle.
//  5. Reset mid-hold: assert rstNI at cycle 15 of a hold, release at cycle 18, key still low.
//     -> all outputs 0 during reset; pressO pulses 6 cycles after rstNI rises; no releaseO.

Source files
------------

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types, constants and width helper for the key event generator
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_t;

  // Raw key level when not pressed (keys are active-low).
  localparam logic KEY_RELEASED = 1'b1;

  // Bits needed to hold a count from 0 up to max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_event_ch.sv
// rtl/key_event_ch.sv - one key channel: sync, debounce, event FSM, hold/repeat counters (KEY_REPEAT_EN)
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int DEB_CYC  = 240_000,
  parameter int LONG_CYC = 12_000_000
`ifdef KEY_REPEAT_EN
  ,
  parameter int REP_CYC  = 2_400_000
`endif
) (
  input  logic clkI,
  input  logic rstNI,
  input  logic keyI,
  output logic heldO,
  output logic pressO,
  output logic releaseO,
  output logic longO
);

  localparam int DW = cnt_w(DEB_CYC);
  localparam int HW = cnt_w(LONG_CYC);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          pressed_smp;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          held_q, held_d;
  key_state_t    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

`ifdef KEY_REPEAT_EN
  localparam int RW = cnt_w(REP_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_CYC - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Two-flop synchroniser; both flops come out of reset at the released level.
  always_ff @(posedge clkI or negedge rstNI) begin
    if (!rstNI) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
    end else begin
      sync1_q <= keyI;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_smp = (sync2_q != KEY_RELEASED);

  // Debounce: count consecutive samples disagreeing with the accepted level, flip on the DEB_CYC-th.
  always_comb begin
    deb_cnt_d = '0;
    held_d    = held_q;
    if (pressed_smp != held_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        held_d = pressed_smp;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Event FSM: decisions use the next debounced level so pulses line up with the heldO change.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (held_d && !held_q) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!held_d) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
`ifdef KEY_REPEAT_EN
        // Repeat timing runs off the LONG entry; a repeat due on the release cycle still fires.
        if (rep_cnt_q == REP_LAST) begin
          press_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
        if (!held_d) begin
          state_d   = IDLE;
          release_d = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel state and registered event pulses.
  always_ff @(posedge clkI or negedge rstNI) begin
    if (!rstNI) begin
      deb_cnt_q  <= '0;
      held_q     <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      held_q     <= held_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat period counter, only alive while in LONG.
  always_ff @(posedge clkI or negedge rstNI) begin
    if (!rstNI) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign heldO    = held_q;
  assign pressO   = press_q;
  assign releaseO = release_q;
  assign longO    = long_q;

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - N_KEYS independent key conditioners; auto-repeat built with KEY_REPEAT_EN
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int N_KEYS   = 4,
  parameter int DEB_CYC  = 240_000,
  parameter int LONG_CYC = 12_000_000
`ifdef KEY_REPEAT_EN
  ,
  parameter int REP_CYC  = 2_400_000
`endif
) (
  input  logic              clkI,
  input  logic              rstNI,
  input  logic [N_KEYS-1:0] keyI,
  output logic [N_KEYS-1:0] heldO,
  output logic [N_KEYS-1:0] pressO,
  output logic [N_KEYS-1:0] releaseO,
  output logic [N_KEYS-1:0] longO
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    key_event_ch #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
`ifdef KEY_REPEAT_EN
      ,
      .REP_CYC  (REP_CYC)
`endif
    ) u_ch (
      .clkI     (clkI),
      .rstNI    (rstNI),
      .keyI     (keyI[k]),
      .heldO    (heldO[k]),
      .pressO   (pressO[k]),
      .releaseO (releaseO[k]),
      .longO    (longO[k])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed and randomized bench for key_event_gen against a window/timestamp model
module tb_key_event_gen;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef KEY_REPEAT_EN
  localparam int REP  = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] held, press, rel, lng;

  always #5 clk = ~clk;

  key_event_gen #(
    .N_KEYS   (NK),
    .DEB_CYC  (DEB),
    .LONG_CYC (LONG)
`ifdef KEY_REPEAT_EN
    ,
    .REP_CYC  (REP)
`endif
  ) dut (
    .clkI     (clk),
    .rstNI    (rst_n),
    .keyI     (key),
    .heldO    (held),
    .pressO   (press),
    .releaseO (rel),
    .longO    (lng)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: raw sample history per key, newest at index 0.
  logic          smp [NK][DEB+2];
  bit            m_held [NK];
  bit            m_pend [NK];
  bit            m_long [NK];
  int            m_press_t [NK];
  int            m_long_t [NK];
  logic [NK-1:0] e_held, e_press, e_rel, e_long;

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < DEB + 2; j++) smp[k][j] = 1'b1;
      m_held[k] = 1'b0;
      m_pend[k] = 1'b0;
      m_long[k] = 1'b0;
    end
    e_held  = '0;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
  endtask

  // A key's accepted level flips when the DEB most recent synchronised samples
  // (raw samples 2..DEB+1 edges old) all disagree with it.
  task automatic model_edge(input logic [NK-1:0] raw);
    cyc++;
    for (int k = 0; k < NK; k++) begin
      bit prev;
      bit flip;
      bit rep;
      for (int j = DEB + 1; j > 0; j--) smp[k][j] = smp[k][j-1];
      smp[k][0] = raw[k];
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) begin
        if ((smp[k][j] == 1'b0) == m_held[k]) flip = 1'b0;
      end
      prev = m_held[k];
      if (flip) m_held[k] = !m_held[k];
      e_held[k]  = m_held[k];
      e_press[k] = m_held[k] && !prev;
      e_rel[k]   = !m_held[k] && prev;
      e_long[k]  = 1'b0;
      rep = 1'b0;
`ifdef KEY_REPEAT_EN
      if (m_long[k] && (cyc > m_long_t[k]) && ((cyc - m_long_t[k]) % REP == 0)) rep = 1'b1;
`endif
      if (e_press[k]) begin
        m_press_t[k] = cyc;
        m_pend[k]    = 1'b1;
      end
      if (m_pend[k] && m_held[k] && (cyc - m_press_t[k] == LONG)) begin
        e_long[k]   = 1'b1;
        m_pend[k]   = 1'b0;
        m_long[k]   = 1'b1;
        m_long_t[k] = cyc;
      end
      if (e_rel[k]) begin
        m_pend[k] = 1'b0;
        m_long[k] = 1'b0;
      end
      e_press[k] = e_press[k] | rep;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(key);
    else model_reset();
    #1;
    chk("held", held, e_held);
    chk("press", press, e_press);
    chk("release", rel, e_rel);
    chk("long", lng, e_long);
  endtask

  task automatic run(input logic [NK-1:0] k, input int n);
    key = k;
    repeat (n) step();
  endtask

  initial begin
    int p_at, r_at, l_at, n_press, n_rel, n_long, n_1001, n_any;

    rst_n = 1'b0;
    key   = '1;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    run(4'b1111, 8);

    // 1. Clean tap on key 0.
    key = 4'b1110; p_at = -1; r_at = -1; n_long = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) key = 4'b1111;
      step();
      if (press[0] && p_at < 0) p_at = i;
      if (rel[0] && r_at < 0) r_at = i;
      if (lng[0]) n_long++;
    end
    chk_int("tap_press_at", p_at, 6);
    chk_int("tap_release_at", r_at, 16);
    chk_int("tap_no_long", n_long, 0);

    // 2. Bounce on key 1, final fall before edge 13.
    p_at = -1; n_press = 0; n_rel = 0;
    for (int i = 1; i <= 30; i++) begin
      key = 4'b1111;
      if (i <= 12) key[1] = ((((i - 1) / 2) % 2) == 1);
      else key[1] = 1'b0;
      step();
      if (press[1]) begin
        n_press++;
        if (p_at < 0) p_at = i;
      end
      if (rel[1]) n_rel++;
    end
    chk_int("bounce_press_cnt", n_press, 1);
    chk_int("bounce_press_at", p_at, 18);
    chk_int("bounce_no_release", n_rel, 0);
    run(4'b1111, 12);

    // 3. Long hold on key 2 for 40 cycles.
    key = 4'b1011; p_at = -1; l_at = -1; n_press = 0; n_rel = 0; r_at = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) key = 4'b1111;
      step();
      if (press[2]) begin
        n_press++;
        if (p_at < 0) p_at = i;
      end
      if (lng[2] && l_at < 0) l_at = i;
      if (rel[2]) begin
        n_rel++;
        r_at = i;
      end
    end
    chk_int("long_press_at", p_at, 6);
    chk_int("long_long_at", l_at, 26);
    chk_int("long_release_cnt", n_rel, 1);
    chk_int("long_release_at", r_at, 46);
`ifdef KEY_REPEAT_EN
    chk_int("long_press_cnt", n_press, 5);
`else
    chk_int("long_press_cnt", n_press, 1);
`endif

    // 4. Keys 0 and 3 fall together.
    key = 4'b0110; n_1001 = 0; n_any = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (press == 4'b1001) n_1001++;
      if (press != 4'b0000) n_any++;
    end
    chk_int("simul_1001_cycles", n_1001, 1);
    chk_int("simul_press_cycles", n_any, 1);
    run(4'b1111, 12);

    // 5. Reset in the middle of a hold on key 0, key still low afterwards.
    run(4'b1110, 15);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_held", held, 4'b0000);
    chk("rst_async_press", press, 4'b0000);
    chk("rst_async_release", rel, 4'b0000);
    chk("rst_async_long", lng, 4'b0000);
    repeat (3) step();
    rst_n = 1'b1;
    p_at = -1; n_rel = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (press[0] && p_at < 0) p_at = i;
      if (rel[0]) n_rel++;
    end
    chk_int("rst_press_at", p_at, 6);
    chk_int("rst_no_release", n_rel, 0);
    run(4'b1111, 12);

    // Randomized key activity, mixing short glitches with real presses and long holds.
    for (int s = 0; s < 120; s++) begin
      logic [NK-1:0] kv;
      int len;
      kv = NK'($urandom());
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
      else len = $urandom_range(5, 35);
      run(kv, len);
    end
    run(4'b1111, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
